// File: rtl/z80_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_pkg
// Brief    : Shared types and constants for the Z80 bus controller.
// Revision : 1.0
// ============================================================================
package z80_bus_pkg;

    localparam int c_vec_w  = 8;
    localparam int c_max_ch = 8;
    localparam int c_idx_w  = $clog2(c_max_ch);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_INTA = 2'd3
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_cegen.sv
`default_nettype none
// ============================================================================
// Module   : cpu_cegen
// Brief    : CPU clock-enable generator: cep at count 0, cen at count DIV/2.
// Revision : 1.0
// ============================================================================
module cpu_cegen #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic cep,
    output logic cen
);

    localparam int                 c_cnt_w = $clog2(DIV);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(DIV / 2);

    logic [c_cnt_w-1:0] r_cnt_q;
    logic [c_cnt_w-1:0] w_cnt_d;
    logic               r_cep_q;
    logic               r_cen_q;
    logic               w_cep_d;
    logic               w_cen_d;

    always_comb begin
        w_cnt_d = (r_cnt_q == c_last) ? '0 : r_cnt_q + 1'b1;
        w_cep_d = (w_cnt_d == '0);
        w_cen_d = (w_cnt_d == c_half);
    end

    // The count parks at DIV-1 so the first clock after release yields cep.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt_q <= c_last;
            r_cep_q <= 1'b0;
            r_cen_q <= 1'b0;
        end else begin
            r_cnt_q <= w_cnt_d;
            r_cep_q <= w_cep_d;
            r_cen_q <= w_cen_d;
        end
    end

    assign cep = r_cep_q;
    assign cen = r_cen_q;

endmodule
`default_nettype wire

// File: rtl/z80_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_ctrl
// Brief    : Z80 bus glue: clock enables, wait-state insertion, IM2 interrupt
//            vectoring and stretched NMI generation.
// Revision : 1.0
// ============================================================================
module z80_bus_ctrl
    import z80_bus_pkg::*;
#(
    parameter int                 DIV      = 4,
    parameter int                 IRQ_CH   = 4,
    parameter int                 MEM_WS   = 0,
    parameter int                 IO_WS    = 1,
    parameter logic [c_vec_w-1:0] VEC_BASE = 8'hE0,
    parameter int                 NMI_LEN  = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic               cep,
    output logic               cen,
    input  logic               mreq,
    input  logic               iorq,
    input  logic               m1,
    input  logic               rd,
    output logic               wait_n,
    input  logic [IRQ_CH-1:0]  irq,
    input  logic [IRQ_CH-1:0]  irq_mask,
    output logic               int_n,
    output logic [IRQ_CH-1:0]  int_ack,
    output logic [c_vec_w-1:0] vec,
    output logic               vec_oe,
    input  logic               nmi_btn,
    output logic               nmi
);

    localparam logic [c_vec_w-1:0] c_vec_spur = c_vec_w'(VEC_BASE + 2 * IRQ_CH);

    bus_state_t          r_state_q, w_state_d;
    logic [2:0]          r_wcnt_q, w_wcnt_d;
    logic [IRQ_CH-1:0]   r_pend_q, w_pend_d;
    logic [IRQ_CH-1:0]   r_ack_q, w_ack_d;
    logic [c_vec_w-1:0]  r_vec_q, w_vec_d;
    logic                w_enter_inta;
    logic                w_sel_valid;
    logic [c_idx_w-1:0]  w_sel_idx;
    logic                r_sync1_q, r_sync2_q, r_armed_q, r_npend_q, r_nact_q;
    logic                w_armed_d, w_npend_d, w_nact_d, w_ntrig;
    logic [3:0]          r_ncnt_q, w_ncnt_d;
    logic                w_unused_rd;

    assign w_unused_rd = rd;

    cpu_cegen #(
        .DIV (DIV)
    ) u_cegen (
        .clock (clock),
        .reset (reset),
        .cep   (cep),
        .cen   (cen)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_q <= ST_IDLE;
            r_wcnt_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_wcnt_q  <= w_wcnt_d;
        end
    end

    // INTA is released on the first clock iorq is seen high, not on cen.
    always_comb begin
        w_state_d    = r_state_q;
        w_wcnt_d     = r_wcnt_q;
        w_enter_inta = 1'b0;
        unique case (r_state_q)
            ST_IDLE: begin
                if (cen) begin
                    if (!mreq && !m1) begin
                        w_state_d = ST_HOLD;
                    end else if (!mreq) begin
                        w_wcnt_d  = 3'(MEM_WS);
                        w_state_d = (MEM_WS != 0) ? ST_WAIT : ST_HOLD;
                    end else if (!iorq && m1) begin
                        w_wcnt_d  = 3'(IO_WS);
                        w_state_d = (IO_WS != 0) ? ST_WAIT : ST_HOLD;
                    end else if (!iorq) begin
                        w_state_d    = ST_INTA;
                        w_enter_inta = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cen) begin
                    w_wcnt_d = r_wcnt_q - 1'b1;
                    if (r_wcnt_q == 3'd1) begin
                        w_state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cen && mreq && iorq) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_INTA: begin
                if (iorq) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_n = (r_state_q != ST_WAIT);
        vec_oe = (r_state_q == ST_INTA);
        int_n  = ~|r_pend_q;
    end

    // Vector and acknowledge are captured only at INTA entry, so later request
    // changes reach int_n but never the vector.
    always_comb begin
        w_pend_d    = irq & irq_mask;
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        for (int i = IRQ_CH - 1; i >= 0; i--) begin
            if (r_pend_q[i]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = c_idx_w'(i);
            end
        end
        w_ack_d = '0;
        w_vec_d = r_vec_q;
        if (w_enter_inta) begin
            if (w_sel_valid) begin
                w_ack_d = IRQ_CH'(1) << w_sel_idx;
                w_vec_d = VEC_BASE + {{(c_vec_w - c_idx_w - 1){1'b0}}, w_sel_idx, 1'b0};
            end else begin
                w_vec_d = c_vec_spur;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend_q <= '0;
            r_ack_q  <= '0;
            r_vec_q  <= VEC_BASE;
        end else begin
            r_pend_q <= w_pend_d;
            r_ack_q  <= w_ack_d;
            r_vec_q  <= w_vec_d;
        end
    end

    assign int_ack = r_ack_q;
    assign vec     = r_vec_q;

    // A pulse needs a high sample (armed) before the low one; it starts on cep.
    always_comb begin
        w_ntrig   = r_armed_q && !r_sync2_q && !r_npend_q && !r_nact_q;
        w_npend_d = r_npend_q | w_ntrig;
        w_nact_d  = r_nact_q;
        w_ncnt_d  = r_ncnt_q;
        if (cep) begin
            if (r_npend_q) begin
                w_npend_d = 1'b0;
                w_nact_d  = 1'b1;
                w_ncnt_d  = 4'(NMI_LEN);
            end else if (r_nact_q) begin
                if (r_ncnt_q == 4'd1) begin
                    w_nact_d = 1'b0;
                end else begin
                    w_ncnt_d = r_ncnt_q - 1'b1;
                end
            end
        end
        if (w_ntrig || r_npend_q || r_nact_q) begin
            w_armed_d = 1'b0;
        end else begin
            w_armed_d = r_armed_q | r_sync2_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1_q <= 1'b1;
            r_sync2_q <= 1'b1;
            r_armed_q <= 1'b0;
            r_npend_q <= 1'b0;
            r_nact_q  <= 1'b0;
            r_ncnt_q  <= '0;
        end else begin
            r_sync1_q <= nmi_btn;
            r_sync2_q <= r_sync1_q;
            r_armed_q <= w_armed_d;
            r_npend_q <= w_npend_d;
            r_nact_q  <= w_nact_d;
            r_ncnt_q  <= w_ncnt_d;
        end
    end

    assign nmi = ~r_nact_q;

endmodule
`default_nettype wire
